alu_nzcv_arbiter: RTL

Shares one combinational alu_nzcv instance between two requesters (e.g. execute unit and address/compare unit) using valid/ready handshakes and round-robin arbitration. Registers the ALU result and NZCV per operation and returns them to the owning requester. Maintains the architectural NZCV flag register, updated only by flag-setting operations.

---
 rtl/alu_arb_pkg.sv | 20 ++
 rtl/alu_nzcv_arbiter_if.sv | 43 ++++
 rtl/alu_nzcv.sv | 47 ++++
 rtl/alu_nzcv_arbiter_rr_arb2.sv | 20 ++
 rtl/alu_nzcv_arbiter.sv | 105 ++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU NZCV arbiter
package alu_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] OR  = 2'b11;

  // NZCV bit positions inside a 4-bit flag vector {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_nzcv_arbiter_if.sv
// rtl/alu_nzcv_arbiter_if.sv - request/response bus between two requesters and the shared ALU
interface alu_nzcv_arbiter_if #(parameter int N = 64);

  logic         i_req0_valid;
  logic         o_req0_ready;
  logic [N-1:0] i_req0_a;
  logic [N-1:0] i_req0_b;
  logic [1:0]   i_req0_ctrl;
  logic         i_req0_set_flags;

  logic         i_req1_valid;
  logic         o_req1_ready;
  logic [N-1:0] i_req1_a;
  logic [N-1:0] i_req1_b;
  logic [1:0]   i_req1_ctrl;
  logic         i_req1_set_flags;

  logic         o_rsp0_valid;
  logic         i_rsp0_ready;
  logic         o_rsp1_valid;
  logic         i_rsp1_ready;
  logic [N-1:0] o_rsp_result;
  logic [3:0]   o_rsp_nzcv;
  logic [3:0]   o_flags;
  logic         o_busy;

  modport master (
    output i_req0_valid, i_req0_a, i_req0_b, i_req0_ctrl, i_req0_set_flags,
    output i_req1_valid, i_req1_a, i_req1_b, i_req1_ctrl, i_req1_set_flags,
    output i_rsp0_ready, i_rsp1_ready,
    input  o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid,
    input  o_rsp_result, o_rsp_nzcv, o_flags, o_busy
  );

  modport slave (
    input  i_req0_valid, i_req0_a, i_req0_b, i_req0_ctrl, i_req0_set_flags,
    input  i_req1_valid, i_req1_a, i_req1_b, i_req1_ctrl, i_req1_set_flags,
    input  i_rsp0_ready, i_rsp1_ready,
    output o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid,
    output o_rsp_result, o_rsp_nzcv, o_flags, o_busy
  );

endinterface

// File: rtl/alu_nzcv.sv
// rtl/alu_nzcv.sv - combinational ADD/SUB/AND/OR with ARM-style NZCV flags
module alu_nzcv
  import alu_arb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   ctrl,
  output logic [N-1:0] result,
  output logic [3:0]   nzcv
);

  logic [N:0] sum;
  logic       carry;
  logic       ovf;

  // Compute result and flags; SUB carry is "no borrow" (a >= b unsigned)
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (ctrl)
      ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[N-1:0];
        carry  = sum[N];
        ovf    = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
      end
      SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        result = sum[N-1:0];
        carry  = sum[N];
        ovf    = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
      end
      AND: result = a & b;
      default: result = a | b;
    endcase
    nzcv         = '0;
    nzcv[FLAG_N] = result[N-1];
    nzcv[FLAG_Z] = (result == '0);
    nzcv[FLAG_C] = carry;
    nzcv[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_nzcv_arbiter_rr_arb2.sv
// rtl/alu_nzcv_arbiter_rr_arb2.sv - two-way round-robin grant selection
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Lone requester wins outright; on contention the pointer decides
  always_comb begin
    gnt_valid = |valid;
    case (valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ptr;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_nzcv_arbiter.sv
// rtl/alu_nzcv_arbiter.sv - shares one alu_nzcv between two requesters with registered responses
module alu_nzcv_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  alu_nzcv_arbiter_if.slave  bus
);

  state_t       state;
  logic         rr_ptr;
  logic         owner;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_nzcv;
  logic [3:0]   flags;

  logic         gnt_valid;
  logic         gnt_idx;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [1:0]   alu_ctrl;
  logic         op_set_flags;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_nzcv_out;
  logic         accept;
  logic         rsp_taken;

  rr_arb2 u_arb (
    .valid     ({bus.i_req1_valid, bus.i_req0_valid}),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Steer the granted requester's operands into the shared ALU
  always_comb begin
    alu_a        = bus.i_req0_a;
    alu_b        = bus.i_req0_b;
    alu_ctrl     = bus.i_req0_ctrl;
    op_set_flags = bus.i_req0_set_flags;
    if (gnt_idx) begin
      alu_a        = bus.i_req1_a;
      alu_b        = bus.i_req1_b;
      alu_ctrl     = bus.i_req1_ctrl;
      op_set_flags = bus.i_req1_set_flags;
    end
  end

  alu_nzcv #(.N(N)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .nzcv   (alu_nzcv_out)
  );

  assign accept    = (state == IDLE) && gnt_valid;
  assign rsp_taken = owner ? bus.i_rsp1_ready : bus.i_rsp0_ready;

  // Control FSM: capture on accept, hold the response until its owner consumes it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      rsp_result <= '0;
      rsp_nzcv   <= '0;
      flags      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_result <= alu_result;
            rsp_nzcv   <= alu_nzcv_out;
            owner      <= gnt_idx;
            rr_ptr     <= ~gnt_idx;
            if (op_set_flags) begin
              flags <= alu_nzcv_out;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_taken) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are forced low for as long as reset is held
  assign bus.o_req0_ready = i_rst_n && accept && !gnt_idx;
  assign bus.o_req1_ready = i_rst_n && accept &&  gnt_idx;
  assign bus.o_rsp0_valid = i_rst_n && (state == RESP) && !owner;
  assign bus.o_rsp1_valid = i_rst_n && (state == RESP) &&  owner;
  assign bus.o_rsp_result = rsp_result;
  assign bus.o_rsp_nzcv   = rsp_nzcv;
  assign bus.o_flags      = flags;
  assign bus.o_busy       = (state == RESP);

endmodule
